// File: rtl/vram_write_arbiter.sv
// VRAM write-port arbiter.
// Drives VRAM port A (v_cea/v_ada/v_din). Two requesters share this port:
//   - the CPU byte-write stream, which has fixed priority;
//   - an internal fill engine that writes one character over a run of text cells.
// A starvation guard hands the fill engine one slot after STARVE_LIMIT back-to-back
// CPU grants made while the fill was waiting.
//
// CPU handshake (valid/ready): cpu_req is valid and cpu_ready is ready. A transfer
// happens on a rising edge where cpu_req and cpu_ready are both 1. cpu_ready is
// combinational and does not depend on cpu_req, so it can be 1 while cpu_req is 0.
// While cpu_req=1 and cpu_ready=0, the CPU holds cpu_addr and cpu_data stable.
// An accepted transfer appears on port A in the next cycle, exactly once.
module vram_write_arbiter #(
  parameter int VRAM_DEPTH   = 1020,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        MEMORY_CLK,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [9:0]  cpu_addr,
  input  logic [7:0]  cpu_data,
  output logic        cpu_ready,
  input  logic        fill_start,
  input  logic [9:0]  fill_base,
  input  logic [10:0] fill_len,
  input  logic [7:0]  fill_char,
  output logic        fill_busy,
  output logic        fill_done,
  output logic        v_cea,
  output logic [9:0]  v_ada,
  output logic [7:0]  v_din
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state_q;
  logic [9:0]     cur_addr_q;
  logic [10:0]    rem_q;
  logic [7:0]     char_q;
  logic [SW-1:0]  streak_q;
  logic           v_cea_q;
  logic [9:0]     v_ada_q;
  logic [7:0]     v_din_q;
  logic           fill_done_q;

  logic           fill_pending;
  logic           starved;
  logic           cpu_grant;
  logic           fill_grant;
  logic [10:0]    len_clamped;
  logic [9:0]     next_addr_d;

  // Arbitration: the CPU wins unless the fill has been passed over STARVE_LIMIT times.
  always_comb begin
    fill_pending = (state_q == RUN);
    starved      = fill_pending && (streak_q == SW'(STARVE_LIMIT));
    cpu_grant    = cpu_req && !starved;
    fill_grant   = fill_pending && !cpu_grant;
    len_clamped  = (fill_len > 11'(VRAM_DEPTH)) ? 11'(VRAM_DEPTH) : fill_len;
    next_addr_d  = (cur_addr_q == 10'(VRAM_DEPTH - 1)) ? 10'd0 : cur_addr_q + 10'd1;
  end

  // Fill FSM, starvation streak and registered port-A outputs.
  always_ff @(posedge MEMORY_CLK) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      rem_q       <= '0;
      char_q      <= '0;
      streak_q    <= '0;
      v_cea_q     <= 1'b0;
      v_ada_q     <= '0;
      v_din_q     <= '0;
      fill_done_q <= 1'b0;
    end else begin
      v_cea_q     <= cpu_grant || fill_grant;
      fill_done_q <= 1'b0;

      // Address and data hold their last values in cycles with no grant.
      if (cpu_grant) begin
        v_ada_q <= cpu_addr;
        v_din_q <= cpu_data;
      end else if (fill_grant) begin
        v_ada_q <= cur_addr_q;
        v_din_q <= char_q;
      end

      // The streak counts only CPU wins taken while the fill was waiting.
      if (!fill_pending || !cpu_req || fill_grant) begin
        streak_q <= '0;
      end else begin
        streak_q <= streak_q + SW'(1);
      end

      case (state_q)
        IDLE: begin
          if (fill_start) begin
            if (len_clamped == 11'd0) begin
              fill_done_q <= 1'b1;
            end else begin
              state_q    <= RUN;
              cur_addr_q <= fill_base;
              rem_q      <= len_clamped;
              char_q     <= fill_char;
            end
          end
        end
        RUN: begin
          // A fill_start arriving here is ignored. The running fill keeps its parameters.
          if (fill_grant) begin
            cur_addr_q <= next_addr_d;
            rem_q      <= rem_q - 11'd1;
            if (rem_q == 11'd1) begin
              state_q     <= IDLE;
              fill_done_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_ready = !starved;
  assign fill_busy = (state_q == RUN);
  assign fill_done = fill_done_q;
  assign v_cea     = v_cea_q;
  assign v_ada     = v_ada_q;
  assign v_din     = v_din_q;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Testbench for vram_write_arbiter.
// Two checking paths run together:
//   - a reference model that holds a pending fill as a queue of cell addresses and
//     checks the DUT every cycle;
//   - a table of directed vectors plus hand-written multi-cycle sequences.
module tb_vram_write_arbiter;

  localparam int DEPTH = 1020;
  localparam int LIMIT = 4;
  localparam int W     = 20;

  // ---------------- clock / reset / signals ----------------
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cpu_req;
  logic [9:0]  cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_ready;
  logic        fill_start;
  logic [9:0]  fill_base;
  logic [10:0] fill_len;
  logic [7:0]  fill_char;
  logic        fill_busy;
  logic        fill_done;
  logic        v_cea;
  logic [9:0]  v_ada;
  logic [7:0]  v_din;

  vram_write_arbiter #(.VRAM_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .MEMORY_CLK (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_data   (cpu_data),
    .cpu_ready  (cpu_ready),
    .fill_start (fill_start),
    .fill_base  (fill_base),
    .fill_len   (fill_len),
    .fill_char  (fill_char),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .v_cea      (v_cea),
    .v_ada      (v_ada),
    .v_din      (v_din)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;

  int         m_cells[$];   // addresses still to be written by the active fill
  logic [7:0] m_char;
  int         m_streak;
  logic [W-1:0] exp_q[$];   // {check_addr_data, cea, ada, din} expected after the edge
  logic       acc;          // a CPU transfer happened in the last cycle
  logic       ready_seen;   // cpu_ready sampled in the last cycle

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle. The model step comes from the arbitration rules.
  // Inputs are assumed set at posedge+1 by the caller.
  task automatic cycle();
    logic pend, e_ready, cg, fg, done;
    logic [9:0] a;
    logic [7:0] d;
    logic [W-1:0] e;
    int clen;
    @(negedge clk);
    pend       = (m_cells.size() > 0);
    e_ready    = !(pend && m_streak == LIMIT);
    ready_seen = cpu_ready;
    if (!rst) check("cpu_ready", cpu_ready, e_ready);
    acc = !rst && cpu_req && cpu_ready;
    done = 1'b0;
    if (rst) begin
      m_cells.delete();
      m_streak = 0;
      e = {1'b1, 1'b0, 10'd0, 8'd0};
    end else begin
      cg = cpu_req && e_ready;
      fg = pend && !cg;
      a  = cg ? cpu_addr : (fg ? 10'(m_cells[0]) : 10'd0);
      d  = cg ? cpu_data : (fg ? m_char : 8'd0);
      e  = {cg | fg, cg | fg, a, d};
      clen = (int'(fill_len) > DEPTH) ? DEPTH : int'(fill_len);
      done = (fg && m_cells.size() == 1) || (!pend && fill_start && clen == 0);
      if (fg) void'(m_cells.pop_front());
      if (fg || !cpu_req || !pend) m_streak = 0;
      else m_streak++;
      if (!pend && fill_start && clen > 0) begin
        m_char = fill_char;
        for (int i = 0; i < clen; i++) m_cells.push_back((int'(fill_base) + i) % DEPTH);
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("v_cea", v_cea, e[18]);
    if (e[19]) begin
      check("v_ada", v_ada, e[17:8]);
      check("v_din", v_din, e[7:0]);
    end
    check("fill_busy", fill_busy, m_cells.size() > 0);
    check("fill_done", fill_done, done);
  endtask

  // ---------------- driver helpers ----------------
  int obs_addr[$];
  int obs_data[$];
  int n_busy, n_done, last_done_addr;
  logic done_on_write;

  // Starts a fill and records port-A activity for ncyc cycles.
  // A second fill_start is sent at cycle index restart_at.
  task automatic run_fill(input int base, input int len, input logic [7:0] ch,
                          input int ncyc, input int restart_at);
    obs_addr.delete();
    obs_data.delete();
    n_busy = 0; n_done = 0; done_on_write = 1'b0; last_done_addr = -1;
    cpu_req = 1'b0; rst = 1'b0;
    fill_start = 1'b1; fill_base = 10'(base); fill_len = 11'(len); fill_char = ch;
    for (int i = 0; i < ncyc; i++) begin
      cycle();
      fill_start = (i + 1 == restart_at);
      if (fill_start) begin
        fill_base = 10'd300; fill_len = 11'd9; fill_char = 8'h44;
      end
      if (fill_busy) n_busy++;
      if (v_cea) begin
        obs_addr.push_back(int'(v_ada));
        obs_data.push_back(int'(v_din));
      end
      if (fill_done) begin
        n_done++;
        done_on_write  = v_cea;
        last_done_addr = int'(v_ada);
      end
    end
    fill_start = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst, req;
    logic [9:0]  addr;
    logic [7:0]  data;
    logic        fs;
    logic [9:0]  base;
    logic [10:0] len;
    logic [7:0]  ch;
    logic        chk_rdy, rdy, cea;
    logic [9:0]  ada;
    logic [7:0]  din;
    logic        busy, done;
  } vec_t;

  vec_t vecs[11];

  // ---------------- main test ----------------
  initial begin
    int nw, nd, nb, bad, k;
    int exp4[4];
    logic is_fill[$];
    int cpu_seen[$];

    rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0; cpu_data = '0;
    fill_start = 1'b0; fill_base = '0; fill_len = '0; fill_char = '0;
    acc = 1'b0;

    // Fields: rst req addr data fs base len ch | chk_rdy rdy cea ada din busy done
    vecs[0]  = '{1, 0, 10'h000, 8'h00, 0, 10'd0,    11'd0, 8'h00, 0, 0, 0, 10'h000, 8'h00, 0, 0};
    vecs[1]  = '{1, 0, 10'h000, 8'h00, 0, 10'd0,    11'd0, 8'h00, 0, 0, 0, 10'h000, 8'h00, 0, 0};
    vecs[2]  = '{0, 1, 10'h123, 8'h41, 0, 10'd0,    11'd0, 8'h00, 1, 1, 1, 10'h123, 8'h41, 0, 0};
    vecs[3]  = '{0, 0, 10'h000, 8'h00, 0, 10'd0,    11'd0, 8'h00, 1, 1, 0, 10'h000, 8'h00, 0, 0};
    vecs[4]  = '{0, 0, 10'h000, 8'h00, 1, 10'd7,    11'd0, 8'h55, 1, 1, 0, 10'h000, 8'h00, 0, 1};
    vecs[5]  = '{0, 0, 10'h000, 8'h00, 0, 10'd0,    11'd0, 8'h00, 1, 1, 0, 10'h000, 8'h00, 0, 0};
    vecs[6]  = '{0, 1, 10'h010, 8'h11, 1, 10'd1019, 11'd2, 8'h2A, 1, 1, 1, 10'h010, 8'h11, 1, 0};
    vecs[7]  = '{0, 1, 10'h011, 8'h12, 0, 10'd0,    11'd0, 8'h00, 1, 1, 1, 10'h011, 8'h12, 1, 0};
    vecs[8]  = '{0, 0, 10'h000, 8'h00, 0, 10'd0,    11'd0, 8'h00, 1, 1, 1, 10'd1019, 8'h2A, 1, 0};
    vecs[9]  = '{0, 0, 10'h000, 8'h00, 0, 10'd0,    11'd0, 8'h00, 1, 1, 1, 10'd0,   8'h2A, 0, 1};
    vecs[10] = '{0, 0, 10'h000, 8'h00, 0, 10'd0,    11'd0, 8'h00, 1, 1, 0, 10'h000, 8'h00, 0, 0};

    for (int i = 0; i < 11; i++) begin
      rst = vecs[i].rst; cpu_req = vecs[i].req; cpu_addr = vecs[i].addr; cpu_data = vecs[i].data;
      fill_start = vecs[i].fs; fill_base = vecs[i].base; fill_len = vecs[i].len; fill_char = vecs[i].ch;
      cycle();
      if (vecs[i].chk_rdy) check("tbl_ready", ready_seen, vecs[i].rdy);
      check("tbl_cea", v_cea, vecs[i].cea);
      if (vecs[i].cea || vecs[i].rst) begin
        check("tbl_ada", v_ada, vecs[i].ada);
        check("tbl_din", v_din, vecs[i].din);
      end
      check("tbl_busy", fill_busy, vecs[i].busy);
      check("tbl_done", fill_done, vecs[i].done);
    end
    rst = 1'b0; cpu_req = 1'b0; fill_start = 1'b0;

    // Full-screen clear: 1020 back-to-back writes, done with the last one.
    run_fill(0, 1020, 8'h20, 1025, -1);
    check("clear_writes", obs_addr.size(), 1020);
    check("clear_busy_cycles", n_busy, 1020);
    check("clear_done_count", n_done, 1);
    check("clear_done_on_write", done_on_write, 1);
    check("clear_done_addr", last_done_addr, 1019);
    bad = 0;
    foreach (obs_addr[i]) if (obs_addr[i] != i || obs_data[i] != 'h20) bad++;
    check("clear_sequence_bad", bad, 0);

    // Wrap across the end of VRAM.
    run_fill(1018, 4, 8'h2E, 8, -1);
    exp4 = '{1018, 1019, 0, 1};
    check("wrap_writes", obs_addr.size(), 4);
    for (int i = 0; i < 4; i++)
      check("wrap_addr", (i < obs_addr.size()) ? obs_addr[i] : -1, exp4[i]);

    // Length clamp: 2000 cells becomes 1020, ending just before the base.
    run_fill(5, 2000, 8'h30, 1025, -1);
    check("clamp_writes", obs_addr.size(), 1020);
    check("clamp_last_addr", last_done_addr, 4);
    check("clamp_done_count", n_done, 1);

    // A fill_start while busy is ignored.
    run_fill(200, 5, 8'h33, 20, 2);
    check("restart_writes", obs_addr.size(), 5);
    bad = 0;
    foreach (obs_addr[i]) if (obs_addr[i] != 200 + i || obs_data[i] != 'h33) bad++;
    check("restart_bad", bad, 0);
    check("restart_done_count", n_done, 1);

    // Zero-length fill: done only, no writes, never busy.
    run_fill(7, 0, 8'h55, 5, -1);
    check("zero_writes", obs_addr.size(), 0);
    check("zero_busy", n_busy, 0);
    check("zero_done", n_done, 1);

    // Contention: the CPU streams every cycle during an 8-cell fill.
    fill_start = 1'b1; fill_base = 10'd100; fill_len = 11'd8; fill_char = 8'hEE;
    cycle();
    fill_start = 1'b0;
    k = 0;
    for (int i = 0; i < 60; i++) begin
      cpu_req = 1'b1; cpu_addr = 10'(k); cpu_data = 8'(k);
      cycle();
      if (acc) k++;
      if (v_cea) begin
        is_fill.push_back(v_din == 8'hEE);
        if (v_din != 8'hEE) cpu_seen.push_back(int'(v_din));
      end
    end
    cpu_req = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++)
      if (i >= is_fill.size() || is_fill[i] != (i % 5 == 4)) bad++;
    check("starve_pattern_bad", bad, 0);
    check("starve_cpu_count", cpu_seen.size(), k);
    bad = 0;
    foreach (cpu_seen[i]) if (cpu_seen[i] != i) bad++;
    check("starve_cpu_order_bad", bad, 0);

    // Reset at cell 3 of 10 aborts the fill silently.
    fill_start = 1'b1; fill_base = 10'd50; fill_len = 11'd10; fill_char = 8'h77;
    cycle();
    fill_start = 1'b0;
    nw = 0;
    for (int i = 0; i < 20 && nw < 3; i++) begin
      cycle();
      if (v_cea) nw++;
    end
    check("abort_writes_before", nw, 3);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    nw = 0; nd = 0; nb = 0;
    for (int i = 0; i < 15; i++) begin
      cycle();
      if (v_cea) nw++;
      if (fill_done) nd++;
      if (fill_busy) nb++;
    end
    check("abort_writes_after", nw, 0);
    check("abort_done", nd, 0);
    check("abort_busy", nb, 0);

    // Reset held for 2 cycles in the middle of mixed traffic.
    fill_start = 1'b1; fill_base = 10'd10; fill_len = 11'd50; fill_char = 8'h61;
    cpu_req = 1'b1; cpu_addr = 10'd5; cpu_data = 8'd9;
    cycle();
    fill_start = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    rst = 1'b1;
    cycle();
    cycle();
    check("rst_cea", v_cea, 0);
    check("rst_ada", v_ada, 0);
    check("rst_din", v_din, 0);
    check("rst_busy", fill_busy, 0);
    check("rst_done", fill_done, 0);
    rst = 1'b0; cpu_req = 1'b0;
    cycle();
    check("rst_after_cea", v_cea, 0);

    // Randomized traffic against the model.
    acc = 1'b0;
    for (int n = 0; n < 2500; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (!cpu_req || acc) begin
        cpu_req  = ($urandom_range(0, 3) != 0);
        cpu_addr = 10'($urandom);
        cpu_data = 8'($urandom);
      end
      fill_start = ($urandom_range(0, 29) == 0);
      fill_base  = 10'($urandom_range(0, DEPTH - 1));
      case ($urandom_range(0, 9))
        0:       fill_len = 11'd0;
        9:       fill_len = 11'($urandom_range(1000, 2047));
        default: fill_len = 11'($urandom_range(1, 30));
      endcase
      fill_char = 8'($urandom);
      cycle();
    end
    rst = 1'b0; cpu_req = 1'b0; fill_start = 1'b0;
    for (int i = 0; i < 1100 && m_cells.size() > 0; i++) cycle();
    check("drain_empty", m_cells.size(), 0);
    cycle();
    check("drain_idle_busy", fill_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so that the run always ends.
  initial begin
    #5000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
